// File: rtl/fir_axil_core.sv
// rtl/fir_axil_core.sv - AXI4-Lite FIR filter core with one-tap-per-cycle MAC engine
// Optional level interrupt output IRQ is built when FIR_IRQ_EN is defined.
module fir_axil_core #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int TAPS               = 8,
  parameter int SAMPLE_W           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
`ifdef FIR_IRQ_EN
  output logic                            IRQ,
`endif
  input  logic                            S_AXI_RREADY
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int WA_W   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PROD_W = 2 * SAMPLE_W;
  localparam int ACC_W  = 2 * SAMPLE_W + 4;
  localparam int IDX_W  = $clog2(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic        [IDX_W-1:0]    idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] x_q    [TAPS];
  logic signed [SAMPLE_W-1:0] coef_q [TAPS];
  logic        [DW-1:0]       dout_q;
  logic                       done_q;
  logic                       awready_q, bvalid_q, arready_q, rvalid_q;
  logic        [1:0]          bresp_q;
  logic        [DW-1:0]       rdata_q;
`ifdef FIR_IRQ_EN
  logic                       irq_en_q, irq_q;
`endif

  logic              wr_fire, rd_fire, busy;
  logic [WA_W-1:0]   wr_idx, rd_idx;
  logic              din_hit, din_accept, clr_accept, ctrl_wr, coef_wr, coef_rd;
  logic [IDX_W-1:0]  coef_widx, coef_ridx;
  logic [DW-1:0]     rd_val, sat_val;
  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       acc_w;
  logic              unused_ok;

  assign wr_fire    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire    = arready_q && S_AXI_ARVALID;
  assign wr_idx     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign busy       = (state_q != S_IDLE);
  assign din_hit    = wr_fire && (wr_idx == WA_W'(2));
  assign din_accept = din_hit && !busy;
  assign ctrl_wr    = wr_fire && (wr_idx == WA_W'(0)) && S_AXI_WSTRB[0];
  assign clr_accept = ctrl_wr && S_AXI_WDATA[0] && !busy;
  assign coef_wr    = wr_fire && (wr_idx >= WA_W'(4)) && (wr_idx < WA_W'(4 + TAPS));
  assign coef_rd    = (rd_idx >= WA_W'(4)) && (rd_idx < WA_W'(4 + TAPS));
  assign coef_widx  = IDX_W'(wr_idx - WA_W'(4));
  assign coef_ridx  = IDX_W'(rd_idx - WA_W'(4));

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_WDATA, S_AXI_WSTRB};

  // Operands are widened before the multiply so the full signed product is kept.
  assign prod  = PROD_W'(x_q[idx_q]) * PROD_W'(coef_q[idx_q]);
  assign acc_w = 64'(acc_q);

  always_comb begin
    sat_val = acc_w[DW-1:0];
    if (acc_w > 64'sd2147483647)       sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (acc_w < -64'sd2147483648) sat_val = {1'b1, {(DW-1){1'b0}}};
  end

  always_comb begin
    rd_val = '0;
    if (rd_idx == WA_W'(0)) begin
`ifdef FIR_IRQ_EN
      rd_val = DW'({irq_en_q, 1'b0});
`endif
    end else if (rd_idx == WA_W'(1)) begin
      rd_val = DW'({done_q, busy});
    end else if (rd_idx == WA_W'(3)) begin
      rd_val = dout_q;
    end else if (coef_rd) begin
      rd_val = DW'(coef_q[coef_ridx]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (din_accept) begin
        state_d = S_MAC;
        idx_d   = '0;
        acc_d   = '0;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(TAPS - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
`ifdef FIR_IRQ_EN
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;

      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (din_hit && busy) ? 2'b10 : 2'b00;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      if (din_accept) begin
        x_q[0] <= S_AXI_WDATA[SAMPLE_W-1:0];
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end else if (clr_accept) begin
        for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      end

      if (coef_wr) begin
        for (int b = 0; b < SAMPLE_W; b++)
          if (S_AXI_WSTRB[b/8]) coef_q[coef_widx][b] <= S_AXI_WDATA[b];
      end

      // A completing result wins over a same-cycle STATUS read so DONE is never lost.
      if (state_q == S_DONE) begin
        dout_q <= sat_val;
        done_q <= 1'b1;
      end else if (rd_fire && rd_idx == WA_W'(1)) begin
        done_q <= 1'b0;
      end
`ifdef FIR_IRQ_EN
      if (ctrl_wr) irq_en_q <= S_AXI_WDATA[1];
      irq_q <= done_q && irq_en_q;
`endif
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
`ifdef FIR_IRQ_EN
  assign IRQ           = irq_q;
`endif

endmodule

// File: tb/tb_fir_axil_core.sv
// tb/tb_fir_axil_core.sv - self-checking bench for fir_axil_core (IRQ checks under FIR_IRQ_EN)
module tb_fir_axil_core;
  localparam int TAPS = 8;
  localparam int SW   = 16;
  localparam int AW   = 7;
`ifdef FIR_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h2;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef FIR_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  fir_axil_core #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .TAPS(TAPS), .SAMPLE_W(SW)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
`ifdef FIR_IRQ_EN
    .IRQ(irq),
`endif
    .S_AXI_RREADY(rready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: delay line and coefficients as plain signed numbers.
  logic signed [SW-1:0] m_x [TAPS];
  logic signed [SW-1:0] m_c [TAPS];

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  function automatic logic [31:0] model_out();
    longint s = 0;
    logic [63:0] u;
    for (int k = 0; k < TAPS; k++) s += longint'(m_x[k]) * longint'(m_c[k]);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    u = s;
    return u[31:0];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_x[k] = '0;
      m_c[k] = '0;
    end
  endfunction

  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      timeout("axi_wr");
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
      return;
    end
    chk("wready_with_awready", {31'b0, wready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout("bvalid"); resp = 2'b11; return; end
    resp = bresp;
  endtask

  task automatic axi_rd(input logic [6:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin timeout("axi_rd"); arvalid = 1'b0; d = 'x; return; end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin timeout("rvalid"); d = 'x; return; end
    chk("rresp", {30'b0, rresp}, 32'h0);
    d = rdata;
  endtask

  task automatic wr_coef(input int k, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    axi_wr(7'(8'h10 + 4 * k), d, s, r);
    chk("coef_bresp", {30'b0, r}, 32'h0);
    if (s[0]) m_c[k][7:0]  = d[7:0];
    if (s[1]) m_c[k][15:8] = d[15:8];
  endtask

  task automatic set_all_coef(input logic [15:0] v);
    for (int k = 0; k < TAPS; k++) wr_coef(k, {16'h0, v}, 4'hF);
  endtask

  task automatic do_clr();
    logic [1:0] r;
    axi_wr(7'h00, 32'h1, 4'hF, r);
    chk("clr_bresp", {30'b0, r}, 32'h0);
    for (int k = 0; k < TAPS; k++) m_x[k] = '0;
  endtask

  task automatic do_din(input logic [31:0] v, input logic exp_busy);
    logic [1:0] r;
    axi_wr(7'h08, v, 4'($urandom_range(0, 15)), r);
    chk(exp_busy ? "din_busy_bresp" : "din_bresp", {30'b0, r}, exp_busy ? 32'h2 : 32'h0);
    if (!exp_busy) begin
      for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0] = v[SW-1:0];
    end
  endtask

  task automatic wait_done();
    repeat (TAPS + 4) @(negedge clk);
  endtask

  task automatic chk_dout(input string nm);
    logic [31:0] d;
    axi_rd(7'h0C, d);
    chk(nm, d, model_out());
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctl"}, {25'b0, awready, wready, bvalid, arready, rvalid, bresp | rresp}, 32'h0);
    chk({nm, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r;
    logic [31:0] old_c;

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    axi_rd(7'h04, d); chk("status_after_reset", d, 32'h0);
    axi_rd(7'h0C, d); chk("dout_after_reset", d, 32'h0);

    // Register-access vectors: writes check BRESP, reads check RDATA.
    tbl.push_back('{1'b1, 7'h10, 32'h0000_1234, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h10, 32'h0,         4'h0, 32'h0000_1234});
    tbl.push_back('{1'b1, 7'h10, 32'h0000_AB56, 4'h1, 32'h0});
    tbl.push_back('{1'b0, 7'h13, 32'h0,         4'h0, 32'h0000_1256});
    tbl.push_back('{1'b1, 7'h14, 32'h0000_8001, 4'h3, 32'h0});
    tbl.push_back('{1'b0, 7'h14, 32'h0,         4'h0, 32'hFFFF_8001});
    tbl.push_back('{1'b1, 7'h14, 32'h0000_7F00, 4'h2, 32'h0});
    tbl.push_back('{1'b0, 7'h14, 32'h0,         4'h0, 32'h0000_7F01});
    tbl.push_back('{1'b1, 7'h2C, 32'h0000_5555, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 7'h2C, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 7'h30, 32'h1234_5678, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h30, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 7'h7C, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h7C, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b0, 7'h08, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 7'h0C, 32'h0000_DEAD, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h0C, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 7'h00, 32'h0000_0003, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h00, 32'h0,         4'h0, CTRL_RB});
    tbl.push_back('{1'b1, 7'h00, 32'h0000_0000, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h04, 32'h0,         4'h0, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_wr(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        chk($sformatf("tbl[%0d] bresp", i), {30'b0, r}, tbl[i].exp);
      end else begin
        axi_rd(tbl[i].addr, d);
        chk($sformatf("tbl[%0d] rdata", i), d, tbl[i].exp);
      end
    end
    m_c[0] = 16'h1256;
    m_c[1] = 16'h7F01;

    // Impulse response with COEF[k]=k+1, DOUT boundary at TAPS+1 cycles after BVALID.
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32'(k + 1), 4'hF);
    do_clr();
    do_din(32'd1, 1'b0);
    repeat (TAPS - 1) @(negedge clk);
    axi_rd(7'h0C, d); chk("dout_not_yet_at_T", d, 32'h0);
    wait_done();
    chk_dout("impulse_1");
    do_din(32'd0, 1'b0);
    repeat (TAPS) @(negedge clk);
    axi_rd(7'h0C, d); chk("dout_at_T_plus_1", d, 32'd2);
    chk("impulse_model_2", d, model_out());
    wait_done();
    do_din(32'd0, 1'b0);
    wait_done();
    axi_rd(7'h0C, d); chk("impulse_3", d, 32'd3);

    // Ramp 1..8 with unit coefficients; DONE is sticky until read.
    set_all_coef(16'h0001);
    do_clr();
    for (int v = 1; v <= TAPS; v++) begin
      do_din(32'(v), 1'b0);
      wait_done();
    end
    axi_rd(7'h0C, d); chk("ramp_sum", d, 32'h24);
    axi_rd(7'h04, d); chk("status_done", d, 32'h2);
    axi_rd(7'h04, d); chk("status_cleared", d, 32'h0);

    // DIN and CLR while busy are rejected/ignored.
    do_din(32'd5, 1'b0);
    do_din(32'd9, 1'b1);
    wait_done();
    chk_dout("busy_din_dropped");
    do_din(32'd7, 1'b0);
    axi_wr(7'h00, 32'h1, 4'hF, r);
    chk("clr_busy_bresp", {30'b0, r}, 32'h0);
    wait_done();
    chk_dout("clr_busy_result");
    do_din(32'd0, 1'b0);
    wait_done();
    chk_dout("clr_busy_ignored");

    // Negative coefficient and saturation in both directions.
    wr_coef(0, 32'h0000_FFFF, 4'hF);
    do_clr();
    do_din(32'd3, 1'b0);
    wait_done();
    axi_rd(7'h0C, d); chk("neg_coef", d, 32'hFFFF_FFFD);
    set_all_coef(16'h7FFF);
    for (int v = 0; v < TAPS; v++) begin do_din(32'h7FFF, 1'b0); wait_done(); end
    axi_rd(7'h0C, d); chk("sat_pos", d, 32'h7FFF_FFFF);
    set_all_coef(16'h8000);
    do_din(32'h7FFF, 1'b0);
    wait_done();
    axi_rd(7'h0C, d); chk("sat_neg", d, 32'h8000_0000);

    // BVALID/RVALID hold while the master stalls.
    bready = 1'b0;
    wr_coef(2, 32'h0000_0042, 4'hF);
    repeat (3) begin @(negedge clk); chk("bvalid_hold", {30'b0, bvalid, bresp[1]}, 32'h2); end
    bready = 1'b1;
    @(negedge clk);
    chk("bvalid_release", {31'b0, bvalid}, 32'h0);
    rready = 1'b0;
    axi_rd(7'h18, d);
    repeat (3) begin @(negedge clk); chk("rvalid_hold", {rdata[30:0], rvalid}, {31'h42, 1'b1}); end
    rready = 1'b1;
    @(negedge clk);
    chk("rvalid_release", {31'b0, rvalid}, 32'h0);

    // Same-cycle read and write of one register: read sees the old value.
    old_c = {{16{m_c[3][15]}}, m_c[3]};
    fork
      axi_wr(7'h1C, 32'h0000_0BCD, 4'hF, r);
      axi_rd(7'h1C, d);
    join
    m_c[3] = 16'h0BCD;
    chk("concurrent_rd_old", d, old_c);
    axi_rd(7'h1C, d); chk("concurrent_wr_new", d, 32'h0000_0BCD);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 30; it++) begin
      int k;
      if ($urandom_range(0, 3) == 0) do_clr();
      k = $urandom_range(0, TAPS - 1);
      wr_coef(k, $urandom, 4'($urandom_range(0, 15)));
      axi_rd(7'(8'h10 + 4 * k), d);
      chk("rand_coef_rb", d, {{16{m_c[k][15]}}, m_c[k]});
      do_din($urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) do_din($urandom, 1'b1);
      wait_done();
      axi_rd(7'h04, d); chk("rand_status", d, 32'h2);
      chk_dout("rand_dout");
    end

    // Reset in the middle of MAC.
    set_all_coef(16'h0003);
    do_din(32'd11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outputs_zero("mid_mac_reset");
    @(negedge clk);
    chk_outputs_zero("mid_mac_reset_edge");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    axi_rd(7'h0C, d); chk("reset_dout", d, 32'h0);
    axi_rd(7'h14, d); chk("reset_coef1", d, 32'h0);
    axi_rd(7'h04, d); chk("reset_status", d, 32'h0);
    wr_coef(0, 32'h1, 4'hF);
    do_din(32'd5, 1'b0);
    wait_done();
    axi_rd(7'h0C, d); chk("post_reset_dout", d, 32'd5);

`ifdef FIR_IRQ_EN
    axi_wr(7'h00, 32'h2, 4'hF, r);
    do_din(32'd1, 1'b0);
    repeat (TAPS + 1) @(negedge clk);
    chk("irq_low_at_done", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    axi_rd(7'h04, d2);
    chk("irq_status", d2, 32'h2);
    chk("irq_held_at_read", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
